// File: rtl/cg_phase_scheduler.sv
// Phase sequencer for a conjugate-gradient solver: launches the A*p, dot-product,
// divider and vector-update units in order and tracks iterations and timeouts.
module cg_phase_scheduler #(
    parameter int NO_OF_UNITS = 8,
    parameter int ITER_W      = 11,
    parameter int TIMEOUT     = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       total,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              converged,
    input  logic              mxv_done,
    input  logic              dot_done,
    input  logic              div_done,
    input  logic              upd_done,
    output logic              mxv_go,
    output logic              dot_go,
    output logic              div_go,
    output logic              upd_go,
    output logic              dot_sel,
    output logic              div_sel,
    output logic              upd_sel,
    output logic [31:0]       vec_words,
    output logic [ITER_W-1:0] iteration_counter,
    output logic [3:0]        phase,
    output logic              busy,
    output logic              halt,
    output logic              err
);
    localparam int SHIFT = $clog2(NO_OF_UNITS);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        INIT_RR = 4'd1,
        MXV     = 4'd2,
        DOT_PAP = 4'd3,
        ALPHA   = 4'd4,
        UPD_XR  = 4'd5,
        DOT_RR  = 4'd6,
        BETA    = 4'd7,
        UPD_P   = 4'd8,
        DONE    = 4'd9
    } state_t;

    state_t            state_reg, state_next, succ_state;
    logic [31:0]       cnt_reg;
    logic [31:0]       vec_words_reg;
    logic [ITER_W-1:0] max_iter_reg, iter_reg, iter_inc;
    logic              err_reg, err_next;
    logic              mxv_go_reg, dot_go_reg, div_go_reg, upd_go_reg;
    logic              dot_sel_reg, div_sel_reg, upd_sel_reg;
    logic              busy_reg, halt_reg;
    logic              unit_done, done_ok, timed_out, is_wait, go_now, last_iter;

    assign iter_inc  = (&iter_reg) ? iter_reg : iter_reg + 1'b1;
    assign last_iter = (max_iter_reg != '0) && (iter_inc == max_iter_reg);
    assign is_wait   = state_reg inside {INIT_RR, MXV, DOT_PAP, ALPHA, UPD_XR, DOT_RR, BETA, UPD_P};
    // cnt 0 is the entry cycle, cnt 1 the go cycle; only later dones count.
    assign done_ok   = unit_done && (cnt_reg >= 32'd2);
    assign timed_out = (cnt_reg == 32'(TIMEOUT - 1));
    assign go_now    = is_wait && (cnt_reg == 32'd0) && (state_next == state_reg);

    always_comb begin
        unit_done  = 1'b0;
        succ_state = IDLE;
        case (state_reg)
            INIT_RR: begin unit_done = dot_done; succ_state = MXV;     end
            MXV:     begin unit_done = mxv_done; succ_state = DOT_PAP; end
            DOT_PAP: begin unit_done = dot_done; succ_state = ALPHA;   end
            ALPHA:   begin unit_done = div_done; succ_state = UPD_XR;  end
            UPD_XR:  begin unit_done = upd_done; succ_state = DOT_RR;  end
            DOT_RR:  begin unit_done = dot_done; succ_state = converged ? DONE : BETA; end
            BETA:    begin unit_done = div_done; succ_state = UPD_P;   end
            UPD_P:   begin unit_done = upd_done; succ_state = last_iter ? DONE : MXV; end
            default: begin unit_done = 1'b0;     succ_state = IDLE;    end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        if (state_reg == IDLE || state_reg == DONE) begin
            if (start) begin
                state_next = INIT_RR;
                err_next   = 1'b0;
            end
        end else if (state_reg == INIT_RR && vec_words_reg == 32'd0) begin
            state_next = DONE;
            err_next   = 1'b1;
        end else if (done_ok) begin
            state_next = succ_state;
        end else if (timed_out) begin
            state_next = DONE;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            vec_words_reg <= '0;
            max_iter_reg  <= '0;
            iter_reg      <= '0;
            err_reg       <= 1'b0;
            mxv_go_reg    <= 1'b0;
            dot_go_reg    <= 1'b0;
            div_go_reg    <= 1'b0;
            upd_go_reg    <= 1'b0;
            dot_sel_reg   <= 1'b0;
            div_sel_reg   <= 1'b0;
            upd_sel_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            halt_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (state_next != state_reg)
                cnt_reg <= '0;
            else if (cnt_reg != '1)
                cnt_reg <= cnt_reg + 32'd1;
            if ((state_reg == IDLE || state_reg == DONE) && start) begin
                vec_words_reg <= total >> SHIFT;
                max_iter_reg  <= max_iter;
                iter_reg      <= '0;
            end else if (state_reg == UPD_P && done_ok) begin
                iter_reg <= iter_inc;
            end
            mxv_go_reg  <= go_now && (state_reg == MXV);
            dot_go_reg  <= go_now && (state_reg inside {INIT_RR, DOT_PAP, DOT_RR});
            div_go_reg  <= go_now && (state_reg inside {ALPHA, BETA});
            upd_go_reg  <= go_now && (state_reg inside {UPD_XR, UPD_P});
            // Selects follow the state being entered so they are stable for its whole stay.
            dot_sel_reg <= (state_next == INIT_RR) || (state_next == DOT_RR);
            div_sel_reg <= (state_next == BETA);
            upd_sel_reg <= (state_next == UPD_P);
            busy_reg    <= state_next inside {INIT_RR, MXV, DOT_PAP, ALPHA, UPD_XR, DOT_RR, BETA, UPD_P};
            halt_reg    <= (state_next == DONE);
        end
    end

    assign mxv_go            = mxv_go_reg;
    assign dot_go            = dot_go_reg;
    assign div_go            = div_go_reg;
    assign upd_go            = upd_go_reg;
    assign dot_sel           = dot_sel_reg;
    assign div_sel           = div_sel_reg;
    assign upd_sel           = upd_sel_reg;
    assign vec_words         = vec_words_reg;
    assign iteration_counter = iter_reg;
    assign phase             = state_reg;
    assign busy              = busy_reg;
    assign halt              = halt_reg;
    assign err               = err_reg;
endmodule

// File: tb/tb_cg_phase_scheduler.sv
// Bench for cg_phase_scheduler: table of full solves with an auto-responding unit
// model, plus hand sequences for stray dones, timeout and mid-phase reset.
module tb_cg_phase_scheduler;
    localparam int ITER_W = 11;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [31:0]       total = '0;
    logic [ITER_W-1:0] max_iter = '0;
    logic              converged;
    logic              mxv_done, dot_done, div_done, upd_done;
    logic              mxv_go, dot_go, div_go, upd_go;
    logic              dot_sel, div_sel, upd_sel;
    logic [31:0]       vec_words;
    logic [ITER_W-1:0] iteration_counter;
    logic [3:0]        phase;
    logic              busy, halt, err;

    logic a_mxv, a_dot, a_div, a_upd;
    logic m_mxv = 1'b0, m_dot = 1'b0, m_div = 1'b0, m_upd = 1'b0;
    assign mxv_done = a_mxv | m_mxv;
    assign dot_done = a_dot | m_dot;
    assign div_done = a_div | m_div;
    assign upd_done = a_upd | m_upd;

    cg_phase_scheduler #(.NO_OF_UNITS(8), .ITER_W(ITER_W), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .total(total), .max_iter(max_iter),
        .converged(converged), .mxv_done(mxv_done), .dot_done(dot_done),
        .div_done(div_done), .upd_done(upd_done), .mxv_go(mxv_go), .dot_go(dot_go),
        .div_go(div_go), .upd_go(upd_go), .dot_sel(dot_sel), .div_sel(div_sel),
        .upd_sel(upd_sel), .vec_words(vec_words), .iteration_counter(iteration_counter),
        .phase(phase), .busy(busy), .halt(halt), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int go_log[$];
    bit auto_en = 1'b1;
    int conv_at = 0;

    // Unit model: each done pulse lands 5 cycles after its go; logs go codes.
    initial begin
        int cd_mxv, cd_dot, cd_div, cd_upd, rr_idx;
        cd_mxv = 0; cd_dot = 0; cd_div = 0; cd_upd = 0; rr_idx = 0;
        a_mxv = 0; a_dot = 0; a_div = 0; a_upd = 0; converged = 0;
        forever begin
            @(posedge clk); #1;
            a_mxv = 0; a_dot = 0; a_div = 0; a_upd = 0;
            if (cd_mxv > 0) begin cd_mxv--; if (cd_mxv == 0) a_mxv = 1; end
            if (cd_dot > 0) begin cd_dot--; if (cd_dot == 0) a_dot = 1; end
            if (cd_div > 0) begin cd_div--; if (cd_div == 0) a_div = 1; end
            if (cd_upd > 0) begin cd_upd--; if (cd_upd == 0) a_upd = 1; end
            if (mxv_go) begin go_log.push_back(2); if (auto_en) cd_mxv = 5; end
            if (dot_go) begin
                go_log.push_back(dot_sel ? 1 : 3);
                if (auto_en) cd_dot = 5;
                if (phase == 4'd1) rr_idx = 0;
                if (phase == 4'd6) rr_idx++;
                converged = (phase == 4'd6) && (rr_idx == conv_at);
            end
            if (div_go) begin go_log.push_back(div_sel ? 7 : 4); if (auto_en) cd_div = 5; end
            if (upd_go) begin go_log.push_back(upd_sel ? 8 : 5); if (auto_en) cd_upd = 5; end
            if (reset) begin cd_mxv = 0; cd_dot = 0; cd_div = 0; cd_upd = 0; end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_phase(input logic [3:0] p, input int budget, output int n);
        n = 0;
        while (phase != p && n < budget) begin step(); n++; end
        if (phase != p) n = -1;
    endtask

    task automatic pulse_done(input logic [3:0] p);
        case (p)
            4'd2:       m_mxv = 1;
            4'd4, 4'd7: m_div = 1;
            4'd5, 4'd8: m_upd = 1;
            default:    m_dot = 1;
        endcase
        step();
        m_mxv = 0; m_dot = 0; m_div = 0; m_upd = 0;
    endtask

    task automatic adv(input logic [3:0] p);
        int n;
        wait_phase(p, 50, n);
        chk($sformatf("reach_phase%0d", p), 64'(n >= 0), 64'd1);
        step(); step();
        pulse_done(p);
    endtask

    task automatic kick(input logic [31:0] t, input logic [ITER_W-1:0] m);
        total = t; max_iter = m; start = 1; step(); start = 0;
    endtask

    function automatic logic [63:0] zero_vec();
        return {phase, mxv_go, dot_go, div_go, upd_go, dot_sel, div_sel, upd_sel,
                busy, halt, err, 11'(iteration_counter), vec_words};
    endfunction

    typedef struct {
        logic [31:0]       total;
        logic [ITER_W-1:0] max_iter;
        int                conv;
        int                exp_iter;
        logic              exp_err;
        logic [31:0]       exp_vw;
    } vec_t;
    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input string tag);
        int n, base;
        int exp_q[$];
        bit same;
        conv_at = v.conv;
        base = go_log.size();
        kick(v.total, v.max_iter);
        wait_phase(4'd9, 3000, n);
        chk({tag, "_reach_done"}, 64'(n >= 0), 64'd1);
        step(); step();
        chk({tag, "_phase"}, 64'(phase), 64'd9);
        chk({tag, "_halt_busy"}, {62'd0, halt, busy}, 64'b10);
        chk({tag, "_err"}, 64'(err), 64'(v.exp_err));
        chk({tag, "_iter"}, 64'(iteration_counter), 64'(v.exp_iter));
        chk({tag, "_vec_words"}, 64'(vec_words), 64'(v.exp_vw));
        if (v.exp_vw != 0) begin
            exp_q.push_back(1);
            for (int i = 0; i < v.exp_iter; i++) begin
                exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5);
                exp_q.push_back(1); exp_q.push_back(7); exp_q.push_back(8);
            end
            if (v.conv > 0 && v.exp_iter == v.conv - 1) begin
                exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5);
                exp_q.push_back(1);
            end
        end
        same = (go_log.size() - base == exp_q.size());
        if (same)
            for (int i = 0; i < exp_q.size(); i++)
                if (go_log[base + i] != exp_q[i]) same = 0;
        chk({tag, "_go_order_len"}, 64'(go_log.size() - base), 64'(exp_q.size()));
        chk({tag, "_go_order_ok"}, 64'(same), 64'd1);
        $display("vec %s: total=%0d max_iter=%0d conv_at=%0d -> iter=%0d err=%0d vec_words=%0d gos=%0d",
                 tag, v.total, v.max_iter, v.conv, iteration_counter, err, vec_words,
                 go_log.size() - base);
    endtask

    initial begin
        int n, k;
        vecs[0] = '{32'd64,  11'd3, 0, 3, 1'b0, 32'd8};
        vecs[1] = '{32'd64,  11'd0, 2, 1, 1'b0, 32'd8};
        vecs[2] = '{32'd4,   11'd3, 0, 0, 1'b1, 32'd0};
        vecs[3] = '{32'd100, 11'd1, 0, 1, 1'b0, 32'd12};
        vecs[4] = '{32'd8,   11'd5, 1, 0, 1'b0, 32'd1};
        vecs[5] = '{32'd64,  11'd2, 2, 1, 1'b0, 32'd8};
        vecs[6] = '{32'd16,  11'd1, 1, 0, 1'b0, 32'd2};

        repeat (3) step();
        reset = 0;
        step();
        chk("reset_outputs", zero_vec(), 64'd0);
        $display("reset: phase=%0d busy=%0d halt=%0d", phase, busy, halt);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // total below one word: INIT_RR then DONE, no launches.
        k = go_log.size();
        kick(32'd4, 11'd3);
        chk("short_cycle1_phase", 64'(phase), 64'd1);
        step();
        chk("short_cycle2_phase", 64'(phase), 64'd9);
        chk("short_err", 64'(err), 64'd1);
        step(); step();
        chk("short_no_go", 64'(go_log.size() - k), 64'd0);
        $display("short: phase=%0d err=%0d", phase, err);

        // Manual units: go-cycle done, stray done, then divider timeout in ALPHA.
        auto_en = 0;
        conv_at = 0;
        kick(32'd64, 11'd3);
        chk("go_cycle_dot_go", 64'(dot_go), 64'd0);
        step();
        chk("go_cycle_dot_go_hi", {63'd0, dot_go}, 64'd1);
        m_dot = 1; step(); m_dot = 0;
        chk("go_cycle_done_ignored", 64'(phase), 64'd1);
        pulse_done(4'd1);
        chk("init_advance", 64'(phase), 64'd2);
        adv(4'd2);
        adv(4'd3);
        wait_phase(4'd4, 50, n);
        chk("reach_alpha", 64'(n >= 0), 64'd1);
        k = 0;
        step(); k++;
        chk("alpha_div_go_sel", {62'd0, div_go, div_sel}, 64'b10);
        step(); k++;
        m_mxv = 1; step(); k++; m_mxv = 0;
        chk("stray_mxv_ignored", 64'(phase), 64'd4);
        chk("alpha_busy_halt", {62'd0, busy, halt}, 64'b10);
        while (phase != 4'd9 && k < 40) begin step(); k++; end
        chk("timeout_cycles", 64'(k), 64'd16);
        chk("timeout_err", 64'(err), 64'd1);
        $display("timeout: done after %0d cycles err=%0d", k, err);

        // Reset in the middle of UPD_XR, then a late done.
        kick(32'd64, 11'd3);
        adv(4'd1); adv(4'd2); adv(4'd3); adv(4'd4);
        wait_phase(4'd5, 50, n);
        chk("reach_upd_xr", 64'(n >= 0), 64'd1);
        step();
        reset = 1; step(); reset = 0;
        chk("midreset_outputs", zero_vec(), 64'd0);
        step();
        m_upd = 1; step(); m_upd = 0;
        step(); step();
        chk("late_done_ignored", zero_vec(), 64'd0);
        $display("midreset: phase=%0d busy=%0d", phase, busy);

        auto_en = 1;
        run_vec(vecs[0], "fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cg_phase_scheduler.md
CG_PHASE_SCHEDULER -- requirements
Module: cg_phase_scheduler

Interface
REQ-001 SHALL have parameter NO_OF_UNITS, default 8, number of parallel lanes per vector word (power of two).
REQ-002 SHALL have parameter ITER_W, default 11, width of the iteration counter.
REQ-003 SHALL have parameter TIMEOUT, default 65535, maximum cycles allowed in any wait state.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 start  input  1  level; request a solve while idle.
REQ-007 total  input  32  vector length in elements; sampled at accepted start.
REQ-008 max_iter  input  ITER_W  iteration limit; sampled at accepted start.
REQ-009 converged  input  1  residual-below-threshold flag; valid whenever dot_done is high in DOT_RR.
REQ-010 mxv_done, dot_done, div_done, upd_done  input  1 each  single-cycle completion pulses from the A*p, dot-product, divider and vector-update units.
REQ-011 mxv_go, dot_go, div_go, upd_go  output  1 each  single-cycle launch pulses.
REQ-012 dot_sel  output  1  0 = p'Ap, 1 = r'r.
REQ-013 div_sel  output  1  0 = alpha, 1 = beta.
REQ-014 upd_sel  output  1  0 = x/r update, 1 = p update.
REQ-015 vec_words  output  32  total / NO_OF_UNITS, latched at start.
REQ-016 iteration_counter  output  ITER_W  completed iterations.
REQ-017 phase  output  4  current state encoding.
REQ-018 busy, halt, err  output  1 each  running / finished / finished abnormally.

Function
REQ-019 States, with encodings: IDLE=0, INIT_RR=1, MXV=2, DOT_PAP=3, ALPHA=4, UPD_XR=5, DOT_RR=6, BETA=7, UPD_P=8, DONE=9.
REQ-020 In IDLE, start=1 SHALL latch vec_words and max_iter, clear iteration_counter, err and halt, and enter INIT_RR.
REQ-021 start SHALL be ignored in every state other than IDLE and DONE; in DONE, start=1 SHALL behave as in IDLE.
REQ-022 On the cycle after entering a wait state, exactly one go pulse SHALL be high for one cycle, with its select stable from entry until exit.
REQ-023 Wait states and their pulses:
- INIT_RR: dot_go, dot_sel=1.
- MXV: mxv_go.
- DOT_PAP: dot_go, dot_sel=0.
- ALPHA: div_go, div_sel=0.
- UPD_XR: upd_go, upd_sel=0.
- DOT_RR: dot_go, dot_sel=1.
- BETA: div_go, div_sel=1.
- UPD_P: upd_go, upd_sel=1.
REQ-024 A state SHALL advance only on the done input of its own unit; done inputs of other units SHALL be ignored; a done arriving in the same cycle as the go pulse SHALL be ignored.
REQ-025 Transitions: INIT_RR->MXV, MXV->DOT_PAP, DOT_PAP->ALPHA, ALPHA->UPD_XR, UPD_XR->DOT_RR.
REQ-026 DOT_RR on dot_done: converged=1 -> DONE with err=0; otherwise -> BETA.
REQ-027 BETA -> UPD_P. UPD_P on upd_done SHALL increment iteration_counter.
REQ-028 After UPD_P: if the incremented count equals max_iter -> DONE with err=0; otherwise -> MXV.
REQ-029 max_iter=0 SHALL mean unlimited; iteration_counter SHALL saturate at all-ones and never wrap.
REQ-030 vec_words=0 at start (total < NO_OF_UNITS) SHALL go directly to DONE with err=1, issuing no go pulse.
REQ-031 A per-state cycle counter SHALL clear on every state entry; if it reaches TIMEOUT before the expected done -> DONE with err=1.
REQ-032 busy SHALL be 1 in states 1-8. halt SHALL be 1 only in DONE. iteration_counter SHALL hold its value in DONE.

Reset
REQ-033 reset SHALL override all inputs and take effect on the next edge in any state, including mid-phase.
REQ-034 After reset: phase=IDLE; all go and select outputs=0; busy=halt=err=0; iteration_counter=0; vec_words=0.
REQ-035 A done pulse arriving after reset SHALL be ignored.

Verification
REQ-036 Inputs total=64, max_iter=3, never converged, each unit done 5 cycles after its go -> go order INIT dot, then 3x(mxv, dot, div, upd, dot, div, upd), halt=1, iteration_counter=3, err=0, vec_words=8.
REQ-037 Inputs total=64, max_iter=0, converged=1 at the 2nd DOT_RR -> DONE after DOT_RR, iteration_counter=1, no second BETA.
REQ-038 Inputs total=4 -> DONE in 2 cycles, err=1, no go pulses.
REQ-039 Stray mxv_done in ALPHA, and a dot_done in the go cycle -> state unchanged.
REQ-040 TIMEOUT=16 with div_done withheld -> DONE 16 cycles after ALPHA entry, err=1.
REQ-041 reset asserted in UPD_XR, followed by a late upd_done -> IDLE, all outputs 0, later done ignored; a fresh start runs normally.
